rx_bit_timing_unit: RTL
=======================

# rx_bit_timing_unit

Parametrised oversampling bit-timing engine for the UART receive path. It sits between the input synchroniser and the receive shift register. It counts oversample ticks and detects the start edge, rejecting false starts. It issues a mid-bit sample pulse and an end-of-bit strobe, tracks the bit position through start, data and stop bits, and flags frame completion and framing errors. It generalises the fixed 16× bit-sample counter to any oversample ratio, data length and stop-bit count, and adds frame-level sequencing.

## Interface
- OSR, 16, oversample ticks per bit; legal 4..256. CW = $clog2(OSR).
- NBITS, 8, data bits per frame; legal 1..16. IW = $clog2(NBITS+1).
- STOP_BITS, 1, stop bits; legal 1 or 2.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  oversample enable; may be held high or pulsed with arbitrary gaps.
- rxd  in  1  serial line, already synchronised; idle high; examined only when tick=1.
- sample  out  1  one-cycle pulse at the mid-bit sample point of data bits.
- sample_val  out  1  rxd value captured at that sample; valid with sample.
- bit_idx  out  IW  index of the current data bit (0 = LSB); valid with sample.
- bit_strobe  out  1  one-cycle pulse at the end of each start or data bit period.
- frame_done  out  1  one-cycle pulse when the last stop bit is sampled.
- framing_err  out  1  one-cycle pulse coincident with frame_done when any stop bit sampled 0.
- false_start  out  1  one-cycle pulse when the start bit samples 1 at mid-point.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, START, DATA, STOP. Tick counter cnt is CW bits wide. Stop counter sidx is 1 bit wide.
- Sample point MID = OSR/2 − 1 (integer division); 7 for OSR=16. End point END = OSR − 1.
- IDLE: cnt=0. On tick with rxd=0, go to START and set cnt=1; that tick counts as tick 0 of the start bit.
- In START, DATA and STOP, each tick increments cnt. When cnt==END on a tick, cnt wraps to 0.
- START:
  - Tick with cnt==MID and rxd=1: pulse false_start, go to IDLE, set cnt=0.
  - Tick with cnt==END: pulse bit_strobe, go to DATA, set bit_idx=0.
- DATA:
  - Tick with cnt==MID: pulse sample, capture sample_val=rxd, present the current bit_idx.
  - Tick with cnt==END: pulse bit_strobe.
    - If bit_idx==NBITS−1, go to STOP with sidx=0.
    - Otherwise increment bit_idx.
- STOP:
  - Tick with cnt==MID: latch an error flag if rxd=0.
    - If sidx==STOP_BITS−1, pulse frame_done, pulse framing_err if the error flag is set, go to IDLE, set cnt=0 and clear the flag.
  - Tick with cnt==END (only when STOP_BITS=2 and sidx=0): increment sidx. No bit_strobe is issued in STOP.
- Returning to IDLE at the last stop mid-point gives half a bit of margin for the next start edge.
- Ticks absent: state, cnt, bit_idx and sidx hold, and no pulses are issued.

## Timing
- All outputs are registered. Each pulse asserts for exactly one clk cycle, in the cycle after the clk edge that samples the qualifying tick.
- sample_val and bit_idx hold their values until the next sample pulse.
- busy rises in the cycle after the start-detect tick. It falls in the same cycle frame_done or false_start asserts.
- Latency from start-detect tick to the first sample: MID + OSR ticks, counted from tick 0 of the start bit. For OSR=16 the first data sample is tick 23.
- With tick held high, one frame occupies OSR·(1+NBITS) + MID + 1 + OSR·(STOP_BITS−1) cycles from start-detect to frame_done.
- Back-to-back frames: a tick with rxd=0 in IDLE is accepted on the first tick after frame_done's causing tick. There is no dead cycle.
- Reset values, from the clk edge with rst=1:
  - state=IDLE; cnt, bit_idx, sidx and the error flag are 0.
  - All outputs are 0, including sample_val and busy.
- rst has priority over tick. Reset mid-frame aborts silently with no frame_done or framing_err.
- rxd glitches between ticks are invisible to the block.

## Test plan
- OSR=16, NBITS=8, tick=1, frame 0x5A sent LSB first with 1 stop bit:
  - 8 sample pulses with sample_val 0,1,0,1,1,0,1,0 and bit_idx 0..7.
  - 9 bit_strobes (start + 8 data).
  - frame_done at cycle 152 after start-detect; framing_err=0.
- False start: rxd low for 5 ticks, then high → false_start at tick 7, busy=0 next cycle, no sample pulses.
- Framing error: stop bit driven 0 → frame_done and framing_err pulse together.
  - With STOP_BITS=2, only the second stop bit driven 0 → still flags framing_err. frame_done arrives OSR ticks later than with one stop bit.
- tick pulsed every 4th cycle, OSR=8, NBITS=5:
  - Pulse spacing scales ×4.
  - Each pulse is exactly 1 cycle wide.
  - Counter holds between ticks.
- Reset asserted at the 3rd data sample:
  - All outputs are 0 on the next cycle and no frame_done follows.
  - A fresh frame after release decodes correctly.
- Back-to-back frames 0xFF then 0x00, with the start edge on the first tick after frame_done: both frames decode and there are two frame_done pulses.

Source files
------------

// File: rtl/rx_bit_timing_unit_if.sv
// Handshake/bus signals between the line front-end and the bit-timing engine.
interface rx_bit_timing_unit_if #(
    parameter int unsigned NBITS = 8
);
    localparam int unsigned IW = $clog2(NBITS + 1);

    logic          tick;
    logic          rxd;
    logic          sample;
    logic          sample_val;
    logic [IW-1:0] bit_idx;
    logic          bit_strobe;
    logic          frame_done;
    logic          framing_err;
    logic          false_start;
    logic          busy;

    // Front-end side: drives the oversample enable and the line.
    modport master (
        output tick, rxd,
        input  sample, sample_val, bit_idx, bit_strobe,
        input  frame_done, framing_err, false_start, busy
    );

    // Engine side.
    modport slave (
        input  tick, rxd,
        output sample, sample_val, bit_idx, bit_strobe,
        output frame_done, framing_err, false_start, busy
    );
endinterface

// File: rtl/rx_bit_timing_unit.sv
// Oversampling bit-timing engine: start detection with false-start rejection,
// mid-bit sampling, end-of-bit strobes and frame sequencing for UART receive.
module rx_bit_timing_unit #(
    parameter int unsigned OSR       = 16,
    parameter int unsigned NBITS     = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input logic                 clk,
    input logic                 rst,
    rx_bit_timing_unit_if.slave rx
);
    localparam int unsigned CW = $clog2(OSR);
    localparam int unsigned IW = $clog2(NBITS + 1);

    localparam logic [CW-1:0] MID       = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] END_PT    = CW'(OSR - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NBITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          sidx_q, sidx_d;
    logic          err_q, err_d;

    logic          sample_q, sample_d;
    logic          sample_val_q, sample_val_d;
    logic [IW-1:0] bit_idx_q, bit_idx_d;
    logic          bit_strobe_q, bit_strobe_d;
    logic          frame_done_q, frame_done_d;
    logic          framing_err_q, framing_err_d;
    logic          false_start_q, false_start_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] cnt_inc;

    // State, counters and registered outputs; rst wins over tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            sidx_q        <= 1'b0;
            err_q         <= 1'b0;
            sample_q      <= 1'b0;
            sample_val_q  <= 1'b0;
            bit_idx_q     <= '0;
            bit_strobe_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            framing_err_q <= 1'b0;
            false_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            sidx_q        <= sidx_d;
            err_q         <= err_d;
            sample_q      <= sample_d;
            sample_val_q  <= sample_val_d;
            bit_idx_q     <= bit_idx_d;
            bit_strobe_q  <= bit_strobe_d;
            frame_done_q  <= frame_done_d;
            framing_err_q <= framing_err_d;
            false_start_q <= false_start_d;
            busy_q        <= busy_d;
        end
    end

    // Tick counter wraps at the end of each bit period.
    assign cnt_inc = (cnt_q == END_PT) ? '0 : cnt_q + CW'(1);

    // Next-state and output decode; nothing moves without a tick.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        sidx_d        = sidx_q;
        err_d         = err_q;
        sample_d      = 1'b0;
        sample_val_d  = sample_val_q;
        bit_idx_d     = bit_idx_q;
        bit_strobe_d  = 1'b0;
        frame_done_d  = 1'b0;
        framing_err_d = 1'b0;
        false_start_d = 1'b0;

        if (rx.tick) begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rx.rxd) begin
                        // The detecting tick is tick 0 of the start bit.
                        state_d = START;
                        cnt_d   = CW'(1);
                    end
                end
                START: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == MID && rx.rxd) begin
                        false_start_d = 1'b1;
                        state_d       = IDLE;
                        cnt_d         = '0;
                    end else if (cnt_q == END_PT) begin
                        bit_strobe_d = 1'b1;
                        state_d      = DATA;
                        idx_d        = '0;
                    end
                end
                DATA: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == MID) begin
                        sample_d     = 1'b1;
                        sample_val_d = rx.rxd;
                        bit_idx_d    = idx_q;
                    end else if (cnt_q == END_PT) begin
                        bit_strobe_d = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = STOP;
                            sidx_d  = 1'b0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                STOP: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == MID) begin
                        if (sidx_q == LAST_STOP) begin
                            // Leave at mid-point to give margin for the next start edge.
                            frame_done_d  = 1'b1;
                            framing_err_d = err_q | ~rx.rxd;
                            state_d       = IDLE;
                            cnt_d         = '0;
                            err_d         = 1'b0;
                        end else begin
                            err_d = err_q | ~rx.rxd;
                        end
                    end else if (cnt_q == END_PT && !sidx_q) begin
                        sidx_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign rx.sample      = sample_q;
    assign rx.sample_val  = sample_val_q;
    assign rx.bit_idx     = bit_idx_q;
    assign rx.bit_strobe  = bit_strobe_q;
    assign rx.frame_done  = frame_done_q;
    assign rx.framing_err = framing_err_q;
    assign rx.false_start = false_start_q;
    assign rx.busy        = busy_q;
endmodule
